// File: rtl/stack_access_unit.sv
// Self-sequencing stack engine: owns the stack pointer and runs push/pop memory cycles.
// Optional bound checking is enabled by defining STACK_BOUND_CHECK_EN.
module stack_access_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 26,
    parameter logic [ADDR_WIDTH-1:0] SP_INIT    = 26'h3FFFFFF,
    parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = 26'h3FFFF00
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [ADDR_WIDTH-1:0] SP,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [1:0]            FAULT,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    input  logic                  MEM_ACK,
    output logic [1:0]            dbg_state
);

    // Memory handshake: a request (MEM_READ or MEM_WRITE) holds address and data
    // stable until the first cycle MEM_ACK is high; that cycle completes the transfer.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_REQ = 2'd1,
        POP_REQ  = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] sp_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  push_cmd;
    logic                  pop_cmd;
    logic                  push_fault;
    logic                  pop_fault;

    // Simultaneous PUSH and POP is deliberately a no-op.
    assign push_cmd = PUSH & ~POP;
    assign pop_cmd  = POP & ~PUSH;

`ifdef STACK_BOUND_CHECK_EN
    logic [1:0] fault_q;

    assign push_fault = (sp_q < SP_LIMIT);
    assign pop_fault  = (sp_q == SP_INIT);
    assign FAULT      = fault_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fault_q <= 2'b00;
        end else if (state == IDLE) begin
            if (push_cmd && push_fault) fault_q[1] <= 1'b1;
            if (pop_cmd && pop_fault)   fault_q[0] <= 1'b1;
        end
    end
`else
    assign push_fault = 1'b0;
    assign pop_fault  = 1'b0;
    assign FAULT      = 2'b00;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            sp_q    <= SP_INIT;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (push_cmd) wdata_q <= WDATA;
                end
                PUSH_REQ: begin
                    if (MEM_ACK) sp_q <= sp_q - ONE;
                end
                POP_REQ: begin
                    if (MEM_ACK) begin
                        rdata_q <= MEM_RDATA;
                        sp_q    <= sp_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // A faulting command skips the memory cycle and goes straight to COMPLETE.
    always_comb begin
        next_state = state;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        MEM_ADDR   = '0;
        MEM_WDATA  = '0;
        case (state)
            IDLE: begin
                if (push_cmd)     next_state = push_fault ? COMPLETE : PUSH_REQ;
                else if (pop_cmd) next_state = pop_fault ? COMPLETE : POP_REQ;
            end
            PUSH_REQ: begin
                MEM_WRITE = 1'b1;
                MEM_ADDR  = sp_q;
                MEM_WDATA = wdata_q;
                if (MEM_ACK) next_state = COMPLETE;
            end
            POP_REQ: begin
                MEM_READ = 1'b1;
                MEM_ADDR = sp_q + ONE;
                if (MEM_ACK) next_state = COMPLETE;
            end
            COMPLETE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign SP        = sp_q;
    assign RDATA     = rdata_q;
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == COMPLETE);
    assign dbg_state = state;

endmodule

// File: tb/tb_stack_access_unit.sv
// Bench for stack_access_unit: directed vector table, corner sequences and a
// randomized run against an address-level stack model with a latency-programmable memory.
module tb_stack_access_unit;

    localparam int             DW       = 32;
    localparam int             AW       = 26;
    localparam logic [AW-1:0]  SP_INIT  = 26'h3FFFFFF;
    localparam logic [AW-1:0]  SP_LIMIT = 26'h3FFFF00;
`ifdef STACK_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          PUSH;
    logic          POP;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;
    logic [AW-1:0] SP;
    logic          BUSY;
    logic          DONE;
    logic [1:0]    FAULT;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic          MEM_ACK;
    logic [1:0]    dbg_state;

    stack_access_unit dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .WDATA(WDATA),
        .RDATA(RDATA), .SP(SP), .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ACK(MEM_ACK),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] bench_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q [$];

    int            ack_delay  = 0;
    bit            force_ack  = 1'b0;
    int            mem_cycles = 0;
    logic          last_write = 1'b0;
    logic [AW-1:0] last_addr  = '0;
    bit            hold_err   = 1'b0;
    bit            both_err   = 1'b0;

    function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks a request ack_delay cycles after it first appears.
    initial begin : mem_responder
        bit            req_active;
        int            wait_cnt;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic          s_write;
        req_active = 1'b0;
        wait_cnt   = 0;
        s_addr     = '0;
        s_wdata    = '0;
        s_write    = 1'b0;
        MEM_ACK    = 1'b0;
        MEM_RDATA  = '0;
        forever begin
            @(negedge CLK);
            #1;
            MEM_ACK = force_ack;
            if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both_err = 1'b1;
            if (!(MEM_READ === 1'b1 || MEM_WRITE === 1'b1)) begin
                req_active = 1'b0;
            end else begin
                if (!req_active) begin
                    req_active = 1'b1;
                    wait_cnt   = ack_delay;
                    s_addr     = MEM_ADDR;
                    s_wdata    = MEM_WDATA;
                    s_write    = MEM_WRITE;
                end else if (MEM_ADDR !== s_addr || MEM_WDATA !== s_wdata || MEM_WRITE !== s_write) begin
                    hold_err = 1'b1;
                end
                if (wait_cnt == 0) begin
                    if (MEM_WRITE === 1'b1) bench_mem[MEM_ADDR] = MEM_WDATA;
                    else MEM_RDATA = bench_mem.exists(MEM_ADDR) ? bench_mem[MEM_ADDR] : default_word(MEM_ADDR);
                    MEM_ACK    = 1'b1;
                    mem_cycles++;
                    last_write = MEM_WRITE;
                    last_addr  = MEM_ADDR;
                    req_active = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic do_reset();
        RST   = 1'b0;
        PUSH  = 1'b0;
        POP   = 1'b0;
        WDATA = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Latency counts the command cycle as 1; returns at a negedge back in IDLE.
    task automatic run_op(input bit do_push, input bit do_pop, input logic [DW-1:0] data,
                          input int delay, output int lat);
        ack_delay = delay;
        PUSH  = do_push;
        POP   = do_pop;
        WDATA = data;
        lat   = 1;
        @(negedge CLK);
        PUSH = 1'b0;
        POP  = 1'b0;
        lat  = 2;
        while (DONE !== 1'b1 && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        check("done_seen", 64'(DONE), 64'(1));
        @(negedge CLK);
        check("done_single_pulse", 64'(DONE), 64'(0));
    endtask

    typedef struct {
        bit            push;
        logic [DW-1:0] wdata;
        int            delay;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] exp_sp;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            lat;
        int            c0;
        int            n;
        logic [AW-1:0] m_sp;
        logic [1:0]    m_fault;
        logic [DW-1:0] ref_mem [logic [AW-1:0]];
        bit            is_push;
        bit            fault_op;
        logic [DW-1:0] d;
        int            dly;

        vecs[0] = '{1'b1, 32'hDEADBEEF, 1, 26'h3FFFFFF, 26'h3FFFFFE, 32'h00000000, 4};
        vecs[1] = '{1'b0, 32'h00000000, 0, 26'h3FFFFFF, 26'h3FFFFFF, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b1, 32'h12345678, 3, 26'h3FFFFFF, 26'h3FFFFFE, 32'hDEADBEEF, 6};
        vecs[3] = '{1'b1, 32'hCAFEF00D, 0, 26'h3FFFFFE, 26'h3FFFFFD, 32'hDEADBEEF, 3};
        vecs[4] = '{1'b0, 32'h00000000, 2, 26'h3FFFFFE, 26'h3FFFFFE, 32'hCAFEF00D, 5};
        vecs[5] = '{1'b0, 32'h00000000, 1, 26'h3FFFFFF, 26'h3FFFFFF, 32'h12345678, 4};

        @(negedge CLK);
        do_reset();
        check("rst_sp", 64'(SP), 64'(SP_INIT));
        check("rst_rdata", 64'(RDATA), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_done", 64'(DONE), 64'(0));
        check("rst_fault", 64'(FAULT), 64'(0));
        check("rst_mem_read", 64'(MEM_READ), 64'(0));
        check("rst_mem_write", 64'(MEM_WRITE), 64'(0));
        check("rst_mem_addr", 64'(MEM_ADDR), 64'(0));
        check("rst_mem_wdata", 64'(MEM_WDATA), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        repeat (3) @(negedge CLK);
        check("idle_no_mem_cycle", 64'(mem_cycles), 64'(0));
        check("idle_busy", 64'(BUSY), 64'(0));

        for (int i = 0; i < 6; i++) begin
            c0 = mem_cycles;
            run_op(vecs[i].push, !vecs[i].push, vecs[i].wdata, vecs[i].delay, lat);
            check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            check("vec_mem_cycles", 64'(mem_cycles - c0), 64'(1));
            check("vec_mem_is_write", 64'(last_write), 64'(vecs[i].push));
            check("vec_mem_addr", 64'(last_addr), 64'(vecs[i].exp_addr));
            check("vec_sp", 64'(SP), 64'(vecs[i].exp_sp));
            check("vec_rdata", 64'(RDATA), 64'(vecs[i].exp_rdata));
            check("vec_busy_after", 64'(BUSY), 64'(0));
        end
        check("vec_written_word", 64'(bench_mem[26'h3FFFFFF]), 64'(32'h12345678));

        // PUSH+POP together is a no-op; a PUSH during BUSY must not start a second cycle.
        c0 = mem_cycles;
        PUSH = 1'b1; POP = 1'b1; WDATA = 32'h0BADF00D;
        @(negedge CLK);
        PUSH = 1'b0; POP = 1'b0;
        check("both_busy", 64'(BUSY), 64'(0));
        check("both_done", 64'(DONE), 64'(0));
        check("both_state", 64'(dbg_state), 64'(0));
        @(negedge CLK);
        check("both_done_later", 64'(DONE), 64'(0));
        check("both_sp", 64'(SP), 64'(SP_INIT));
        check("both_no_mem", 64'(mem_cycles - c0), 64'(0));
        ack_delay = 3;
        PUSH = 1'b1; WDATA = 32'hA1A1A1A1;
        @(negedge CLK);
        WDATA = 32'hB2B2B2B2;
        @(negedge CLK);
        PUSH = 1'b1; POP = 1'b1;
        @(negedge CLK);
        PUSH = 1'b0; POP = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("busy_cmd_done", 64'(DONE), 64'(1));
        @(negedge CLK);
        repeat (2) @(negedge CLK);
        check("busy_cmd_idle", 64'(BUSY), 64'(0));
        check("busy_cmd_one_cycle", 64'(mem_cycles - c0), 64'(1));
        check("busy_cmd_sp", 64'(SP), 64'(SP_INIT - 26'd1));
        check("busy_cmd_data", 64'(bench_mem[SP_INIT]), 64'(32'hA1A1A1A1));

        // Reset while a write waits for its ack, then a stray ack in IDLE.
        do_reset();
        c0 = mem_cycles;
        ack_delay = 20;
        PUSH = 1'b1; WDATA = 32'h55555555;
        @(negedge CLK);
        PUSH = 1'b0;
        @(negedge CLK);
        check("abort_write_pending", 64'(MEM_WRITE), 64'(1));
        RST = 1'b0;
        @(negedge CLK);
        check("abort_write_drop", 64'(MEM_WRITE), 64'(0));
        check("abort_sp", 64'(SP), 64'(SP_INIT));
        check("abort_busy", 64'(BUSY), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(0));
        RST = 1'b1;
        force_ack = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        force_ack = 1'b0;
        check("stray_ack_busy", 64'(BUSY), 64'(0));
        check("stray_ack_done", 64'(DONE), 64'(0));
        check("stray_ack_sp", 64'(SP), 64'(SP_INIT));
        @(negedge CLK);
        @(negedge CLK);
        check("stray_ack_state", 64'(dbg_state), 64'(0));
        check("abort_no_mem", 64'(mem_cycles - c0), 64'(0));

`ifdef STACK_BOUND_CHECK_EN
        do_reset();
        c0 = mem_cycles;
        run_op(1'b0, 1'b1, '0, 0, lat);
        check("uflow_fault", 64'(FAULT), 64'(2'b01));
        check("uflow_latency", 64'(lat), 64'(2));
        check("uflow_no_mem", 64'(mem_cycles - c0), 64'(0));
        check("uflow_sp", 64'(SP), 64'(SP_INIT));
        n = int'(SP_INIT - SP_LIMIT) + 1;
        for (int i = 0; i < n; i++) run_op(1'b1, 1'b0, DW'(i), 0, lat);
        check("fill_sp", 64'(SP), 64'(SP_LIMIT - 26'd1));
        check("fill_fault", 64'(FAULT), 64'(2'b01));
        c0 = mem_cycles;
        run_op(1'b1, 1'b0, 32'hFFFF0000, 0, lat);
        check("oflow_fault", 64'(FAULT), 64'(2'b11));
        check("oflow_sp", 64'(SP), 64'(SP_LIMIT - 26'd1));
        check("oflow_no_mem", 64'(mem_cycles - c0), 64'(0));
        check("oflow_latency", 64'(lat), 64'(2));
`endif

        // Randomized run against an address-level stack model.
        do_reset();
        bench_mem.delete();
        m_sp    = SP_INIT;
        m_fault = 2'b00;
        for (int i = 0; i < 300; i++) begin
            is_push  = ($urandom_range(0, 9) < 6);
            d        = $urandom;
            dly      = $urandom_range(0, 3);
            fault_op = 1'b0;
            if (is_push) begin
                if (BOUND && m_sp < SP_LIMIT) begin
                    m_fault[1] = 1'b1;
                    fault_op   = 1'b1;
                end else begin
                    ref_mem[m_sp] = d;
                    m_sp          = m_sp - 26'd1;
                end
            end else begin
                if (BOUND && m_sp == SP_INIT) begin
                    m_fault[0] = 1'b1;
                    fault_op   = 1'b1;
                end else begin
                    m_sp = m_sp + 26'd1;
                    exp_q.push_back(ref_mem.exists(m_sp) ? ref_mem[m_sp] : default_word(m_sp));
                end
            end
            run_op(is_push, !is_push, d, dly, lat);
            check("rand_sp", 64'(SP), 64'(m_sp));
            check("rand_fault", 64'(FAULT), 64'(m_fault));
            check("rand_latency", 64'(lat), 64'(fault_op ? 2 : 3 + dly));
            if (!is_push && !fault_op) begin
                if (exp_q.size() == 0) check("rand_queue_empty", 64'(0), 64'(1));
                else check("rand_rdata", 64'(RDATA), 64'(exp_q.pop_front()));
            end
        end

        check("mem_hold_stable", 64'(hold_err), 64'(0));
        check("mem_rd_wr_exclusive", 64'(both_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
